// File: rtl/temp_avg_multi.sv
// temp_avg_multi: multi-channel moving-average filter for temperature samples.
// Each channel keeps a ring buffer of the last 2**LOG2_DEPTH samples and a
// running sum. Every accepted sample produces one registered average
// (latency 1). The block also keeps a window-full flag and a high-temperature
// alarm with hysteresis for each channel.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   sample strobe (at most one sample per cycle)
//   in_ch      in   channel of the sample
//   in_data    in   unsigned temperature sample
//   clr        in   per-channel window flush (wins over a same-cycle sample)
//   out_valid  out  one-cycle pulse when avg_data/avg_ch are updated
//   avg_ch     out  channel of the current average
//   avg_data   out  windowed average of avg_ch (sum >> LOG2_DEPTH)
//   full       out  per-channel: window holds DEPTH samples
//   alarm      out  per-channel high-temperature alarm
//   err_ch     out  one-cycle pulse: sample addressed a channel >= CHANNELS

// Per-channel lane: ring buffer, running sum, fill counter, flags.
module temp_avg_lane #(
   parameter int DATA_W     = 9,
   parameter int LOG2_DEPTH = 3,
   parameter int HI_THRESH  = 40,
   parameter int HYST       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc,
   input  logic              clr,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] avg,
   output logic              full,
   output logic              alarm
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = DATA_W + LOG2_DEPTH;
   localparam logic [DATA_W-1:0] TH_SET = DATA_W'(HI_THRESH);
   localparam logic [DATA_W-1:0] TH_CLR = DATA_W'(HI_THRESH - HYST);

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      new_sum;
   logic [LOG2_DEPTH-1:0] wp;
   logic [LOG2_DEPTH:0]   cnt;
   logic                  fill_now;

   // Evicted entry is 0 while filling, so the subtraction is exact throughout;
   // the combinational read-modify-write keeps back-to-back samples exact.
   assign new_sum  = sum - SUM_W'(mem[wp]) + SUM_W'(data);
   assign avg      = new_sum[SUM_W-1:LOG2_DEPTH];
   assign fill_now = full | (cnt == (LOG2_DEPTH+1)'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         sum   <= '0;
         wp    <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         alarm <= 1'b0;
      end else if (acc) begin
         mem[wp] <= data;
         sum     <= new_sum;
         wp      <= wp + 1'b1;
         if (!full) cnt <= cnt + 1'b1;
         full <= fill_now;
         if (fill_now) begin
            if (avg >= TH_SET)      alarm <= 1'b1;
            else if (avg < TH_CLR)  alarm <= 1'b0;
         end
      end
   end
endmodule

module temp_avg_multi #(
   parameter int CHANNELS   = 2,
   parameter int DATA_W     = 9,
   parameter int LOG2_DEPTH = 3,
   parameter int HI_THRESH  = 40,
   parameter int HYST       = 2,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [CHANNELS-1:0] clr,
   output logic                out_valid,
   output logic [CH_W-1:0]     avg_ch,
   output logic [DATA_W-1:0]   avg_data,
   output logic [CHANNELS-1:0] full,
   output logic [CHANNELS-1:0] alarm,
   output logic                err_ch
);
   logic                            ch_ok;
   logic [CHANNELS-1:0]             acc;
   logic [CHANNELS-1:0][DATA_W-1:0] lane_avg;
   logic [DATA_W-1:0]               avg_sel;

   // Out-of-range channel numbers only exist when CHANNELS is not 2**CH_W.
   generate
      if (CHANNELS == (1 << CH_W)) begin : g_ch_pow2
         assign ch_ok = 1'b1;
      end else begin : g_ch_range
         assign ch_ok = (in_ch < CH_W'(CHANNELS));
      end
   endgenerate

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_lane
         assign acc[g] = in_valid && ch_ok && (in_ch == CH_W'(g)) && !clr[g];
         temp_avg_lane #(
            .DATA_W     (DATA_W),
            .LOG2_DEPTH (LOG2_DEPTH),
            .HI_THRESH  (HI_THRESH),
            .HYST       (HYST)
         ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .acc   (acc[g]),
            .clr   (clr[g]),
            .data  (in_data),
            .avg   (lane_avg[g]),
            .full  (full[g]),
            .alarm (alarm[g])
         );
      end
   endgenerate

   // At most one lane accepts per cycle, so an OR-mux selects its average.
   always_comb begin
      avg_sel = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (acc[i]) avg_sel = avg_sel | lane_avg[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         avg_ch    <= '0;
         avg_data  <= '0;
         err_ch    <= 1'b0;
      end else begin
         out_valid <= |acc;
         err_ch    <= in_valid && !ch_ok;
         if (|acc) begin
            avg_ch   <= in_ch;
            avg_data <= avg_sel;
         end
      end
   end
endmodule
